// File: rtl/riscv_fwd_scoreboard_if.sv
// EX-stage forwarding scoreboard bundle: operand lookup requests and forwarding results.
// Optional perf counter signals exist only when FWD_PERF_CNT_EN is defined.
interface riscv_fwd_scoreboard_if #(
   parameter int XLEN  = 32,
   parameter int RAW   = 5,
   parameter int NSRC  = 2,
   parameter int DEPTH = 3
);
   localparam int SELW = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;

   logic                 pipe_hold;
   logic                 flush;
   logic                 ex_valid;
   logic                 ex_reg_wr;
   logic                 ex_is_load;
   logic [RAW-1:0]       ex_rd_idx;
   logic [XLEN-1:0]      ex_alu_result;
   logic [XLEN-1:0]      mem_load_data;
   logic [NSRC*RAW-1:0]  ex_rs_idx;
   logic [NSRC-1:0]      ex_rs_use;
   logic [NSRC-1:0]      fwd_hit;
   logic [NSRC*SELW-1:0] fwd_stage;
   logic [NSRC*XLEN-1:0] fwd_data;
   logic                 load_use_stall;
`ifdef FWD_PERF_CNT_EN
   logic [31:0]          perf_fwd_cnt;
   logic [31:0]          perf_stall_cnt;
`endif

   modport master (
      output pipe_hold, flush, ex_valid, ex_reg_wr, ex_is_load, ex_rd_idx,
      output ex_alu_result, mem_load_data, ex_rs_idx, ex_rs_use,
      input  fwd_hit, fwd_stage, fwd_data, load_use_stall
`ifdef FWD_PERF_CNT_EN
      , input perf_fwd_cnt, perf_stall_cnt
`endif
   );

   modport slave (
      input  pipe_hold, flush, ex_valid, ex_reg_wr, ex_is_load, ex_rd_idx,
      input  ex_alu_result, mem_load_data, ex_rs_idx, ex_rs_use,
      output fwd_hit, fwd_stage, fwd_data, load_use_stall
`ifdef FWD_PERF_CNT_EN
      , output perf_fwd_cnt, perf_stall_cnt
`endif
   );
endinterface

// File: rtl/riscv_fwd_scoreboard.sv
// EX-stage forwarding scoreboard: DEPTH-entry writeback history, youngest-first operand
// forwarding and internal load-use bubble. FWD_PERF_CNT_EN adds forward/stall counters.
module riscv_fwd_scoreboard #(
   parameter int XLEN  = 32,
   parameter int RAW   = 5,
   parameter int NSRC  = 2,
   parameter int DEPTH = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   riscv_fwd_scoreboard_if.slave  sb
);
   localparam int SELW = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;

   // Entry 0 = EX/MEM, entry 1 = MEM/WB, higher = post-WB shadows.
   logic            valid_reg [DEPTH];
   logic [RAW-1:0]  rd_reg    [DEPTH];
   logic [XLEN-1:0] data_reg  [DEPTH];
   logic            is_load0_reg;

   logic [NSRC-1:0]      hit_vec;
   logic [NSRC*SELW-1:0] stage_vec;
   logic [NSRC*XLEN-1:0] data_vec;
   logic [NSRC-1:0]      lu_vec;
   logic                 stall_int;
   logic                 record_new;

   genvar gi;
   generate
      for (gi = 0; gi < NSRC; gi++) begin : g_src
         logic [RAW-1:0]  rs;
         logic            found;
         logic [SELW-1:0] win;

         assign rs = sb.ex_rs_idx[gi*RAW +: RAW];

         // Scan oldest to youngest so the lowest matching index is left in win.
         always_comb begin
            found = 1'b0;
            win   = '0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
               if (sb.ex_rs_use[gi] && valid_reg[k] && (rd_reg[k] == rs) && (rs != '0)) begin
                  found = 1'b1;
                  win   = SELW'(k);
               end
            end
         end

         assign lu_vec[gi]                 = found && (win == '0) && is_load0_reg;
         assign hit_vec[gi]                = found && !lu_vec[gi];
         assign stage_vec[gi*SELW +: SELW] = win;
         assign data_vec[gi*XLEN +: XLEN]  = hit_vec[gi] ? data_reg[win] : '0;
      end
   endgenerate

   assign stall_int  = (|lu_vec) && sb.ex_valid && !sb.flush;
   assign record_new = sb.ex_valid && sb.ex_reg_wr && !sb.flush && !stall_int &&
                       (sb.ex_rd_idx != '0);

   assign sb.fwd_hit        = rst ? '0   : hit_vec;
   assign sb.fwd_stage      = rst ? '0   : stage_vec;
   assign sb.fwd_data       = rst ? '0   : data_vec;
   assign sb.load_use_stall = rst ? 1'b0 : stall_int;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            valid_reg[k] <= 1'b0;
            rd_reg[k]    <= '0;
            data_reg[k]  <= '0;
         end
         is_load0_reg <= 1'b0;
      end else if (!sb.pipe_hold) begin
         for (int k = DEPTH - 1; k >= 2; k--) begin
            valid_reg[k] <= valid_reg[k-1];
            rd_reg[k]    <= rd_reg[k-1];
            data_reg[k]  <= data_reg[k-1];
         end
         // A load's value becomes known while it sits in entry 0; capture it on the way out.
         valid_reg[1] <= valid_reg[0];
         rd_reg[1]    <= rd_reg[0];
         data_reg[1]  <= is_load0_reg ? sb.mem_load_data : data_reg[0];
         valid_reg[0] <= record_new;
         rd_reg[0]    <= record_new ? sb.ex_rd_idx : '0;
         data_reg[0]  <= record_new ? sb.ex_alu_result : '0;
         is_load0_reg <= record_new && sb.ex_is_load;
      end
   end

`ifdef FWD_PERF_CNT_EN
   logic [31:0] perf_fwd_reg;
   logic [31:0] perf_stall_reg;
   logic [32:0] perf_fwd_next;

   always_comb begin
      perf_fwd_next = {1'b0, perf_fwd_reg};
      for (int i = 0; i < NSRC; i++) begin
         perf_fwd_next = perf_fwd_next + 33'(hit_vec[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fwd_reg   <= '0;
         perf_stall_reg <= '0;
      end else if (!sb.pipe_hold) begin
         perf_fwd_reg <= perf_fwd_next[32] ? 32'hFFFF_FFFF : perf_fwd_next[31:0];
         if (stall_int && (perf_stall_reg != 32'hFFFF_FFFF)) begin
            perf_stall_reg <= perf_stall_reg + 32'd1;
         end
      end
   end

   assign sb.perf_fwd_cnt   = rst ? '0 : perf_fwd_reg;
   assign sb.perf_stall_cnt = rst ? '0 : perf_stall_reg;
`endif
endmodule

// File: tb/tb_riscv_fwd_scoreboard.sv
// Bench for riscv_fwd_scoreboard: cycle table plus hold/stall/reset/aging sequences.
// Builds with DEPTH=4 and perf checks when FWD_PERF_CNT_EN is defined, DEPTH=3 otherwise.
module tb_riscv_fwd_scoreboard;
   localparam int XLEN  = 32;
   localparam int RAW   = 5;
   localparam int NSRC  = 2;
`ifdef FWD_PERF_CNT_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 3;
`endif
   localparam int SELW  = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;

   typedef struct {
      logic        r, h, f, vl, w, ld;
      logic [4:0]  rd;
      logic [31:0] alu, mem;
      logic [4:0]  rs0, rs1;
      logic [1:0]  u;
      logic [1:0]  e_hit;
      int          e_s0, e_s1;
      logic [31:0] e_d0, e_d1;
      logic        e_stall;
   } vec_t;

   typedef struct {
      logic [NSRC-1:0]      hit;
      logic [NSRC*SELW-1:0] stage;
      logic [NSRC*XLEN-1:0] data;
      logic                 stall;
      int                   id;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   exp_t exp_q[$];
   vec_t tbl[$];

   always #5 clk = ~clk;

   riscv_fwd_scoreboard_if #(.XLEN(XLEN), .RAW(RAW), .NSRC(NSRC), .DEPTH(DEPTH)) sb_if ();

   riscv_fwd_scoreboard #(.XLEN(XLEN), .RAW(RAW), .NSRC(NSRC), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .sb  (sb_if)
   );

   function automatic vec_t v(input logic r, h, f, vl, w, ld, input logic [4:0] rd,
                              input logic [31:0] alu, mem, input logic [4:0] rs0, rs1,
                              input logic [1:0] u, eh, input int s0, s1,
                              input logic [31:0] d0, d1, input logic es);
      vec_t t;
      t.r = r; t.h = h; t.f = f; t.vl = vl; t.w = w; t.ld = ld; t.rd = rd;
      t.alu = alu; t.mem = mem; t.rs0 = rs0; t.rs1 = rs1; t.u = u;
      t.e_hit = eh; t.e_s0 = s0; t.e_s1 = s1; t.e_d0 = d0; t.e_d1 = d1; t.e_stall = es;
      return t;
   endfunction

   task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s txn=%0d actual=%h required=%h", name, id, act, req);
      end
   endtask

   task automatic apply(input vec_t t, input int id);
      exp_t e;
      @(posedge clk);
      #1;
      rst                 = t.r;
      sb_if.pipe_hold     = t.h;
      sb_if.flush         = t.f;
      sb_if.ex_valid      = t.vl;
      sb_if.ex_reg_wr     = t.w;
      sb_if.ex_is_load    = t.ld;
      sb_if.ex_rd_idx     = t.rd;
      sb_if.ex_alu_result = t.alu;
      sb_if.mem_load_data = t.mem;
      sb_if.ex_rs_idx     = {t.rs1, t.rs0};
      sb_if.ex_rs_use     = t.u;
      e.hit   = t.e_hit;
      e.stage = {SELW'(t.e_s1), SELW'(t.e_s0)};
      e.data  = {t.e_d1, t.e_d0};
      e.stall = t.e_stall;
      e.id    = id;
      exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front();
      $display("txn %0d hit=%b stage=%h data=%h stall=%b", e.id, sb_if.fwd_hit,
               sb_if.fwd_stage, sb_if.fwd_data, sb_if.load_use_stall);
      chk("fwd_hit",        e.id, 64'(sb_if.fwd_hit),        64'(e.hit));
      chk("fwd_stage",      e.id, 64'(sb_if.fwd_stage),      64'(e.stage));
      chk("fwd_data",       e.id, 64'(sb_if.fwd_data),       64'(e.data));
      chk("load_use_stall", e.id, 64'(sb_if.load_use_stall), 64'(e.stall));
   endtask

   initial begin
      sb_if.pipe_hold = 0; sb_if.flush = 0; sb_if.ex_valid = 0; sb_if.ex_reg_wr = 0;
      sb_if.ex_is_load = 0; sb_if.ex_rd_idx = 0; sb_if.ex_alu_result = 0;
      sb_if.mem_load_data = 0; sb_if.ex_rs_idx = 0; sb_if.ex_rs_use = 0;

      //                r h f vl w ld rd  alu        mem         rs0 rs1 use  ehit  s0 s1 d0          d1          stall
      tbl.push_back(v(1,0,0,1,1,0, 5, 32'h11,    0,          5,  5,  2'b11, 2'b00, 0, 0, 0,          0,          0));
      tbl.push_back(v(0,0,0,1,1,0, 5, 32'h11,    0,          0,  0,  2'b00, 2'b00, 0, 0, 0,          0,          0));
      tbl.push_back(v(0,0,0,1,0,0, 0, 0,         0,          5,  6,  2'b11, 2'b01, 0, 0, 32'h11,     0,          0));
      tbl.push_back(v(0,0,0,1,1,0, 7, 32'hA,     0,          0,  5,  2'b10, 2'b10, 0, 1, 0,          32'h11,     0));
      tbl.push_back(v(0,0,0,1,1,0, 7, 32'hB,     0,          5,  5,  2'b11, 2'b11, 2, 2, 32'h11,     32'h11,     0));
      tbl.push_back(v(0,0,0,1,0,0, 0, 0,         0,          7,  7,  2'b11, 2'b11, 0, 0, 32'hB,      32'hB,      0));
      tbl.push_back(v(0,0,0,1,0,0, 0, 0,         0,          7,  7,  2'b11, 2'b11, 1, 1, 32'hB,      32'hB,      0));
      tbl.push_back(v(0,0,0,1,0,0, 0, 0,         0,          7,  7,  2'b11, 2'b11, 2, 2, 32'hB,      32'hB,      0));
      tbl.push_back(v(0,0,0,1,1,1, 9, 32'h999,   0,          0,  0,  2'b00, 2'b00, 0, 0, 0,          0,          0));
      tbl.push_back(v(0,0,0,1,1,0, 10,32'h55,    32'hDEAD,   0,  9,  2'b10, 2'b00, 0, 0, 0,          0,          1));
      tbl.push_back(v(0,0,0,1,1,0, 10,32'h55,    0,          0,  9,  2'b10, 2'b10, 0, 1, 0,          32'hDEAD,   0));
      tbl.push_back(v(0,0,0,1,1,0, 0, 32'h77,    0,          0,  10, 2'b01, 2'b00, 0, 0, 0,          0,          0));
      tbl.push_back(v(0,0,0,1,0,0, 0, 0,         0,          0,  10, 2'b11, 2'b10, 0, 1, 0,          32'h55,     0));
      tbl.push_back(v(0,0,1,1,1,1, 12,32'h1,     0,          0,  0,  2'b00, 2'b00, 0, 0, 0,          0,          0));
      tbl.push_back(v(0,0,0,1,0,0, 0, 0,         32'hBEEF,   12, 0,  2'b01, 2'b00, 0, 0, 0,          0,          0));
      tbl.push_back(v(0,0,0,1,1,1, 13,32'h13,    0,          0,  0,  2'b00, 2'b00, 0, 0, 0,          0,          0));
      tbl.push_back(v(0,0,1,1,0,0, 0, 0,         32'h1234,   13, 0,  2'b01, 2'b00, 0, 0, 0,          0,          0));
      tbl.push_back(v(0,0,0,1,0,0, 0, 0,         0,          13, 0,  2'b01, 2'b01, 1, 0, 32'h1234,   0,          0));
      foreach (tbl[i]) apply(tbl[i], i);

      // Hold keeps history frozen and records nothing; x21 written under hold must not appear.
      apply(v(1,0,0,0,0,0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0), 100);
      apply(v(0,0,0,1,1,0, 20,32'h2020, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0), 101);
      for (int i = 0; i < 3; i++)
         apply(v(0,1,0,1,1,0, 21,32'h2121, 0, 20, 0, 2'b01, 2'b01, 0, 0, 32'h2020, 0, 0), 102 + i);
      apply(v(0,0,0,1,0,0, 0, 0, 0, 20, 21, 2'b11, 2'b01, 0, 0, 32'h2020, 0, 0), 105);
      apply(v(0,0,0,1,0,0, 0, 0, 0, 20, 0, 2'b01, 2'b01, 1, 0, 32'h2020, 0, 0), 106);

      // Load-use stall persists through hold, then resolves from entry 1.
      apply(v(0,0,0,1,1,1, 22,32'h0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0), 110);
      for (int i = 0; i < 2; i++)
         apply(v(0,1,0,1,0,0, 0, 0, 32'h2222, 22, 0, 2'b01, 2'b00, 0, 0, 0, 0, 1), 111 + i);
      apply(v(0,0,0,1,0,0, 0, 0, 32'h2222, 22, 0, 2'b01, 2'b00, 0, 0, 0, 0, 1), 113);
      apply(v(0,0,0,1,0,0, 0, 0, 0, 22, 0, 2'b01, 2'b01, 1, 0, 32'h2222, 0, 0), 114);

      // Reset while stalled: outputs zero during reset and history empty afterwards.
      apply(v(0,0,0,1,1,1, 23,32'h0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0), 120);
      apply(v(0,0,0,1,0,0, 0, 0, 32'h2323, 23, 0, 2'b01, 2'b00, 0, 0, 0, 0, 1), 121);
      apply(v(1,0,0,1,0,0, 0, 0, 32'h2323, 23, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0), 122);
      apply(v(0,0,0,1,0,0, 0, 0, 32'h2323, 23, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0), 123);

      // A write ages through every entry, then falls off the end.
      apply(v(1,0,0,0,0,0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0), 130);
      apply(v(0,0,0,1,1,0, 25,32'h2525, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0), 131);
      for (int k = 0; k < DEPTH; k++)
         apply(v(0,0,0,1,0,0, 0, 0, 0, 25, 0, 2'b01, 2'b01, k, 0, 32'h2525, 0, 0), 132 + k);
      apply(v(0,0,0,1,0,0, 0, 0, 0, 25, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0), 140);

      // Two hits and one stall after reset.
      apply(v(1,0,0,0,0,0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0), 150);
      apply(v(0,0,0,1,1,0, 3, 32'h33, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0), 151);
      apply(v(0,0,0,1,1,1, 4, 32'h0, 0, 3, 0, 2'b01, 2'b01, 0, 0, 32'h33, 0, 0), 152);
      apply(v(0,0,0,1,0,0, 0, 0, 32'h44, 4, 0, 2'b01, 2'b00, 0, 0, 0, 0, 1), 153);
      apply(v(0,0,0,1,0,0, 0, 0, 0, 4, 0, 2'b01, 2'b01, 1, 0, 32'h44, 0, 0), 154);
      apply(v(0,0,0,0,0,0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0), 155);
`ifdef FWD_PERF_CNT_EN
      chk("perf_fwd_cnt",   155, 64'(sb_if.perf_fwd_cnt),   64'd2);
      chk("perf_stall_cnt", 155, 64'(sb_if.perf_stall_cnt), 64'd1);
      apply(v(1,0,0,0,0,0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0), 156);
      chk("perf_fwd_rst",   156, 64'(sb_if.perf_fwd_cnt),   64'd0);
      chk("perf_stall_rst", 156, 64'(sb_if.perf_stall_cnt), 64'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
